// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: shares the ROB completion write ports among execute units.
// Each requester owns a small skid queue; a round-robin scan drains up to
// NUM_PORTS queue heads per cycle into registered ROB write ports.
// Optional feature macro: ROB_WB_BYPASS_EN lets an empty-queue push compete
// for a port in the same cycle (one cycle less latency when granted).
module rob_wb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 6,
  parameter int DATA_W    = 32,
  parameter int QDEPTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*IDX_W-1:0]      req_idx,
  input  logic [NUM_REQ*DATA_W-1:0]     req_val,
  output logic [NUM_PORTS-1:0]          wb_valid,
  output logic [NUM_PORTS*IDX_W-1:0]    wb_idx,
  output logic [NUM_PORTS*DATA_W-1:0]   wb_val,
  output logic [NUM_REQ-1:0]            pending
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] val;
  } entry_t;

  entry_t             mem     [NUM_REQ][QDEPTH];
  logic [PTR_W-1:0]   rd_ptr  [NUM_REQ];
  logic [PTR_W-1:0]   wr_ptr  [NUM_REQ];
  logic [CNT_W-1:0]   count   [NUM_REQ];
  logic [RR_W-1:0]    rr_ptr;
  logic [RR_W-1:0]    rr_next;

  entry_t             head    [NUM_REQ];
  entry_t             req_ent [NUM_REQ];
  logic [NUM_REQ-1:0] push_acc;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] enq;

  logic [NUM_PORTS-1:0] port_valid;
  entry_t               port_ent   [NUM_PORTS];
  logic [NUM_PORTS-1:0] wb_valid_q;
  entry_t               wb_ent_q   [NUM_PORTS];

  // Per-requester handshake, queue head and candidacy; ready depends only on state.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment, so no latch is inferred.
    req_ready = '0;
    push_acc  = '0;
    cand      = '0;
    pending   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !rst && !flush && (count[i] < CNT_W'(QDEPTH));
      push_acc[i]  = req_valid[i] && req_ready[i];
      pending[i]   = !rst && (count[i] != '0);
      head[i]      = mem[i][rd_ptr[i]];
      req_ent[i]   = '{idx: req_idx[i*IDX_W +: IDX_W], val: req_val[i*DATA_W +: DATA_W]};
`ifdef ROB_WB_BYPASS_EN
      // An empty queue's incoming push competes in the same cycle.
      cand[i]      = (count[i] != '0) || push_acc[i];
`else
      cand[i]      = (count[i] != '0);
`endif
    end
  end

  // Round-robin scan from rr_ptr: the first NUM_PORTS candidates win, in scan order.
  always_comb begin
    int n;
    int slot;
    n          = 0;
    grant      = '0;
    port_valid = '0;
    rr_next    = rr_ptr;
    for (int p = 0; p < NUM_PORTS; p++) port_ent[p] = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = int'(rr_ptr) + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (r == slot && !flush && cand[r] && n < NUM_PORTS) begin
          grant[r] = 1'b1;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (p == n) begin
              port_valid[p] = 1'b1;
              port_ent[p]   = (count[r] != '0) ? head[r] : req_ent[r];
            end
          end
          rr_next = (r == NUM_REQ - 1) ? '0 : RR_W'(r + 1);
          n       = n + 1;
        end
      end
    end
    if (flush) rr_next = '0;
  end

  // A grant on an empty queue is a bypass: nothing to pop and the push is not stored.
  always_comb begin
    pop = '0;
    enq = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i] = grant[i] && (count[i] != '0);
      enq[i] = push_acc[i] && !(grant[i] && (count[i] == '0));
    end
  end

  // Queue pointers, occupancy and the round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst || flush) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      rr_ptr <= rr_next;
      for (int i = 0; i < NUM_REQ; i++) begin
        rd_ptr[i] <= rd_ptr[i] + PTR_W'(pop[i]);
        wr_ptr[i] <= wr_ptr[i] + PTR_W'(enq[i]);
        count[i]  <= count[i] + CNT_W'(enq[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Queue storage write; enq is already blocked by rst and flush via req_ready.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the counts alone decide which entries are meaningful.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (enq[i]) mem[i][wr_ptr[i]] <= req_ent[i];
    end
  end

  // Registered ROB write ports: a grant in one cycle appears on the ports the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) wb_ent_q[p] <= '0;
    end else begin
      wb_valid_q <= port_valid;
      for (int p = 0; p < NUM_PORTS; p++) wb_ent_q[p] <= port_ent[p];
    end
  end

  // Flatten the port registers; outputs read as zero while reset is held.
  always_comb begin
    wb_valid = '0;
    wb_idx   = '0;
    wb_val   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wb_valid[p]                  = !rst && wb_valid_q[p];
      wb_idx[p*IDX_W +: IDX_W]     = rst ? '0 : wb_ent_q[p].idx;
      wb_val[p*DATA_W +: DATA_W]   = rst ? '0 : wb_ent_q[p].val;
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Testbench for rob_wb_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the arbitration rules.
module tb_rob_wb_arbiter;

  localparam int NR = 3;
  localparam int NP = 2;
  localparam int IW = 6;
  localparam int DW = 32;
  localparam int QD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*IW-1:0]  req_idx;
  logic [NR*DW-1:0]  req_val;
  logic [NP-1:0]     wb_valid;
  logic [NP*IW-1:0]  wb_idx;
  logic [NP*DW-1:0]  wb_val;
  logic [NR-1:0]     pending;

  rob_wb_arbiter #(
    .NUM_REQ(NR), .NUM_PORTS(NP), .IDX_W(IW), .DATA_W(DW), .QDEPTH(QD)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .req_val(req_val),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] val;
  } ent_t;

  // Reference model: one FIFO per requester and a round-robin start position.
  ent_t          mq [NR][$];
  int            m_rr;
  logic [NR-1:0] m_ready;
  logic [NR-1:0] s_ready;
  logic [NP-1:0] e_valid;
  logic [IW-1:0] e_idx [NP];
  logic [DW-1:0] e_val [NP];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic set_req(input int i, input logic v, input logic [IW-1:0] idx, input logic [DW-1:0] val);
    req_valid[i]         = v;
    req_idx[i*IW +: IW]  = idx;
    req_val[i*DW +: DW]  = val;
  endtask

  // One clock cycle: check ready before the edge, advance the model, check outputs after.
  task automatic step();
    bit   gr [NR];
    bit   was_empty;
    bit   cand;
    bit   push;
    ent_t in_e;
    int   n;
    int   last;
    int   i;
    @(negedge clk);
    s_ready = req_ready;
    for (int r = 0; r < NR; r++) m_ready[r] = !rst && !flush && (mq[r].size() < QD);
    n_cmp++;
    if (req_ready !== m_ready) begin
      n_bad++;
      $display("FAIL req_ready t=%0t got %b want %b", $time, req_ready, m_ready);
    end
    e_valid = '0;
    for (int p = 0; p < NP; p++) begin
      e_idx[p] = '0;
      e_val[p] = '0;
    end
    if (rst || flush) begin
      for (int r = 0; r < NR; r++) mq[r].delete();
      m_rr = 0;
    end else begin
      n    = 0;
      last = -1;
      for (int r = 0; r < NR; r++) gr[r] = 1'b0;
      for (int k = 0; k < NR; k++) begin
        i    = (m_rr + k) % NR;
        push = req_valid[i] && m_ready[i];
        cand = mq[i].size() > 0;
`ifdef ROB_WB_BYPASS_EN
        cand = cand || push;
`endif
        if (cand && n < NP) begin
          if (mq[i].size() > 0) in_e = mq[i][0];
          else begin
            in_e.idx = req_idx[i*IW +: IW];
            in_e.val = req_val[i*DW +: DW];
          end
          e_valid[n] = 1'b1;
          e_idx[n]   = in_e.idx;
          e_val[n]   = in_e.val;
          gr[i]      = 1'b1;
          last       = i;
          n++;
        end
      end
      for (int r = 0; r < NR; r++) begin
        was_empty = mq[r].size() == 0;
        push      = req_valid[r] && m_ready[r];
        if (gr[r] && !was_empty) void'(mq[r].pop_front());
        if (push && !(gr[r] && was_empty)) begin
          in_e.idx = req_idx[r*IW +: IW];
          in_e.val = req_val[r*DW +: DW];
          mq[r].push_back(in_e);
        end
      end
      if (n > 0) m_rr = (last + 1) % NR;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (wb_valid !== e_valid) begin
      n_bad++;
      $display("FAIL wb_valid t=%0t got %b want %b", $time, wb_valid, e_valid);
    end
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (wb_idx[p*IW +: IW] !== e_idx[p] || wb_val[p*DW +: DW] !== e_val[p]) begin
        n_bad++;
        $display("FAIL wb_port%0d t=%0t got idx=%0h val=%0h want idx=%0h val=%0h", p, $time,
                 wb_idx[p*IW +: IW], wb_val[p*DW +: DW], e_idx[p], e_val[p]);
      end
    end
    for (int r = 0; r < NR; r++) begin
      n_cmp++;
      if (pending[r] !== (mq[r].size() > 0)) begin
        n_bad++;
        $display("FAIL pending%0d t=%0t got %b want %0d", r, $time, pending[r], mq[r].size() > 0);
      end
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0);
  endtask

  task automatic do_flush();
    idle_all();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    idle_all();
    repeat (3) step();
    n_cmp++;
    if (wb_valid !== '0 || pending !== '0 || req_ready !== '0) begin
      n_bad++;
      $display("FAIL reset_state got wb_valid=%b pending=%b req_ready=%b want 0/0/0", wb_valid, pending, req_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_release_ready got %b want 111", req_ready);
    end
    step();
  endtask

  task automatic test_single_push();
    set_req(0, 1'b1, 6'd5, 32'h0000_A5A5);
    step();
    idle_all();
`ifndef ROB_WB_BYPASS_EN
    n_cmp++;
    if (wb_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL single_early got wb_valid=%b want 00", wb_valid);
    end
    step();
`endif
    n_cmp++;
    if (wb_valid !== 2'b01 || wb_idx[IW-1:0] !== 6'd5 || wb_val[DW-1:0] !== 32'h0000_A5A5) begin
      n_bad++;
      $display("FAIL single_push got v=%b idx=%0d val=%0h want v=01 idx=5 val=a5a5",
               wb_valid, wb_idx[IW-1:0], wb_val[DW-1:0]);
    end
    repeat (2) step();
  endtask

  task automatic test_contention();
    do_flush();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, IW'(i + 1), DW'(32'h100 + i));
    step();
    idle_all();
`ifndef ROB_WB_BYPASS_EN
    step();
`endif
    n_cmp++;
    if (wb_valid !== 2'b11 || wb_idx[IW-1:0] !== 6'd1 || wb_idx[2*IW-1:IW] !== 6'd2) begin
      n_bad++;
      $display("FAIL contention_first got v=%b idx0=%0d idx1=%0d want v=11 idx0=1 idx1=2",
               wb_valid, wb_idx[IW-1:0], wb_idx[2*IW-1:IW]);
    end
    step();
    n_cmp++;
    if (wb_valid !== 2'b01 || wb_idx[IW-1:0] !== 6'd3) begin
      n_bad++;
      $display("FAIL contention_second got v=%b idx0=%0d want v=01 idx0=3", wb_valid, wb_idx[IW-1:0]);
    end
    repeat (2) step();
  endtask

  task automatic test_fairness();
    int cnt [NR];
    int mn;
    int mx;
    do_flush();
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, {2'(i), 4'(c)}, $urandom);
      step();
      for (int p = 0; p < NP; p++)
        if (wb_valid[p] && wb_idx[p*IW+4 +: 2] < 2'd3) cnt[wb_idx[p*IW+4 +: 2]]++;
    end
    idle_all();
    mn = cnt[0];
    mx = cnt[0];
    for (int i = 1; i < NR; i++) begin
      if (cnt[i] < mn) mn = cnt[i];
      if (cnt[i] > mx) mx = cnt[i];
    end
    n_cmp++;
    if (mn < 10 || mx - mn > 2) begin
      n_bad++;
      $display("FAIL fairness got grants %0d/%0d/%0d want each >=10 and spread <=2", cnt[0], cnt[1], cnt[2]);
    end
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    int  seq;
    int  next_out;
    bit  saw_bp;
    do_flush();
    seq      = 0;
    next_out = 0;
    saw_bp   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      set_req(0, 1'b1, {2'd0, 4'(c)}, $urandom);
      set_req(1, 1'b1, {2'd1, 4'(c)}, $urandom);
      set_req(2, seq < 12, {2'd2, 4'(seq)}, 32'hB000 + seq);
      step();
      if (req_valid[2] && !s_ready[2]) saw_bp = 1'b1;
      if (req_valid[2] && m_ready[2]) seq++;
      for (int p = 0; p < NP; p++) begin
        if (wb_valid[p] && wb_idx[p*IW+4 +: 2] == 2'd2) begin
          n_cmp++;
          if (wb_idx[p*IW +: 4] !== 4'(next_out) || wb_val[p*DW +: DW] !== 32'hB000 + next_out) begin
            n_bad++;
            $display("FAIL backpressure_order got seq=%0d val=%0h want seq=%0d", wb_idx[p*IW +: 4],
                     wb_val[p*DW +: DW], next_out);
          end
          next_out++;
        end
      end
    end
    idle_all();
    for (int c = 0; c < 4; c++) begin
      step();
      for (int p = 0; p < NP; p++)
        if (wb_valid[p] && wb_idx[p*IW+4 +: 2] == 2'd2) next_out++;
    end
    n_cmp++;
    if (next_out != seq || seq != 12) begin
      n_bad++;
      $display("FAIL backpressure_drain got delivered=%0d accepted=%0d want 12/12", next_out, seq);
    end
`ifndef ROB_WB_BYPASS_EN
    n_cmp++;
    if (!saw_bp) begin
      n_bad++;
      $display("FAIL backpressure_ready got req_ready[2] never low want low once queue full");
    end
`endif
  endtask

  task automatic test_flush();
    do_flush();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, IW'(8 + i + 3*c), $urandom);
      step();
    end
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 6'h3F, 32'hDEAD);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++;
    if (wb_valid !== 2'b00 || pending !== 3'b000) begin
      n_bad++;
      $display("FAIL flush_clear got wb_valid=%b pending=%b want 00/000", wb_valid, pending);
    end
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, IW'(6'h10 + i), 32'h200 + i);
    step();
    idle_all();
`ifndef ROB_WB_BYPASS_EN
    step();
`endif
    n_cmp++;
    if (wb_valid !== 2'b11 || wb_idx[IW-1:0] !== 6'h10 || wb_idx[2*IW-1:IW] !== 6'h11) begin
      n_bad++;
      $display("FAIL flush_restart got v=%b idx0=%0h idx1=%0h want v=11 idx0=10 idx1=11",
               wb_valid, wb_idx[IW-1:0], wb_idx[2*IW-1:IW]);
    end
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      rst   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NR; i++)
        set_req(i, $urandom_range(0, 2) != 0, IW'($urandom), $urandom);
      step();
    end
    rst   = 1'b0;
    flush = 1'b0;
    idle_all();
    repeat (4) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_idx   = '0;
    req_val   = '0;
    m_rr      = 0;
    test_reset();
    test_single_push();
    test_contention();
    test_fairness();
    test_back_to_back();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
